// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: opcodes, NOP encoding and PC width.
// Included by every pipeline-stage module that decodes instructions.
package mips_pkg;

    localparam int PC_W = 10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    // rt is only read as an operand by these formats; elsewhere it is a destination
    function automatic logic rt_is_source(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-operand hazard detection for the ID stage.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       valid_i,
    input  logic [5:0] op_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_write_reg_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_write_reg_i,
    output logic       stall_o
);

    logic isBranch;
    logic exMatchRs;
    logic exMatchRt;
    logic memMatchAny;
    logic loadUse;
    logic branchHazard;

    assign isBranch    = (op_i == OP_BEQ) || (op_i == OP_BNE);
    assign exMatchRs   = (ex_write_reg_i != 5'd0) && (ex_write_reg_i == rs_i);
    assign exMatchRt   = (ex_write_reg_i != 5'd0) && (ex_write_reg_i == rt_i);
    assign memMatchAny = (mem_write_reg_i != 5'd0) &&
                         ((mem_write_reg_i == rs_i) || (mem_write_reg_i == rt_i));

    assign loadUse = ex_mem_read_i && (exMatchRs || (rt_is_source(op_i) && exMatchRt));

    // Branches compare in ID, so any in-flight producer must finish first
    assign branchHazard = isBranch &&
                          ((ex_reg_write_i && (exMatchRs || exMatchRt)) ||
                           (mem_mem_read_i && memMatchAny));

    assign stall_o = valid_i && (loadUse || branchHazard);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with hazard stalls, early branch/jump resolution
// and saturating stall/flush performance counters.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc_plus4_in,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_write_reg,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_write_reg,
    output logic             if_en,
    output logic             branch_taken,
    output logic [PC_W-1:0]  branch_address,
    output logic             jump,
    output logic [PC_W-1:0]  jump_address,
    output logic [PC_W-1:0]  id_pc_plus4,
    output logic [31:0]      id_instr,
    output logic             id_valid,
    output logic             id_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0]      instrQ, instrD;
    logic [PC_W-1:0]  pcQ, pcD;
    logic             validQ, validD;
    logic [CNT_W-1:0] stallCntQ, stallCntD;
    logic [CNT_W-1:0] flushCntQ, flushCntD;

    logic [5:0] op;
    logic       stall;
    logic       flush;
    logic       operandsEqual;

    assign op            = instrQ[31:26];
    assign operandsEqual = (rs_data == rt_data);

    hazard_detect uHazard (
        .valid_i         (validQ),
        .op_i            (op),
        .rs_i            (instrQ[25:21]),
        .rt_i            (instrQ[20:16]),
        .ex_mem_read_i   (ex_mem_read),
        .ex_reg_write_i  (ex_reg_write),
        .ex_write_reg_i  (ex_write_reg),
        .mem_mem_read_i  (mem_mem_read),
        .mem_write_reg_i (mem_write_reg),
        .stall_o         (stall)
    );

    assign branch_taken   = validQ && !stall &&
                            (((op == OP_BEQ) && operandsEqual) ||
                             ((op == OP_BNE) && !operandsEqual));
    assign jump           = validQ && !stall && (op == OP_J);
    assign branch_address = pcQ + {instrQ[7:0], 2'b00};
    assign jump_address   = {instrQ[7:0], 2'b00};
    assign flush          = branch_taken || jump;

    assign if_en     = !stall;
    assign id_bubble = stall;

    // Stall holds, a redirect squashes the wrong-path fetch, otherwise advance
    always_comb begin
        instrD    = instr_in;
        pcD       = pc_plus4_in;
        validD    = 1'b1;
        stallCntD = stallCntQ;
        flushCntD = flushCntQ;
        if (stall) begin
            instrD = instrQ;
            pcD    = pcQ;
            validD = validQ;
        end else if (flush) begin
            instrD = NOP_INSTR;
            pcD    = '0;
            validD = 1'b0;
        end
        if (stall && (stallCntQ != {CNT_W{1'b1}}))
            stallCntD = stallCntQ + 1'b1;
        if (flush && (flushCntQ != {CNT_W{1'b1}}))
            flushCntD = flushCntQ + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instrQ    <= NOP_INSTR;
            pcQ       <= '0;
            validQ    <= 1'b0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            instrQ    <= instrD;
            pcQ       <= pcD;
            validQ    <= validD;
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    assign id_instr    = instrQ;
    assign id_pc_plus4 = pcQ;
    assign id_valid    = validQ;
    assign stall_cnt   = stallCntQ;
    assign flush_cnt   = flushCntQ;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: expected IF/ID contents are queued when
// fetch inputs are driven and compared after the capturing edge.
module tb_if_id_stage;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [9:0]       pc_plus4_in;
    logic [31:0]      instr_in;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_write_reg;
    logic             mem_mem_read;
    logic [4:0]       mem_write_reg;
    logic             if_en;
    logic             branch_taken;
    logic [9:0]       branch_address;
    logic             jump;
    logic [9:0]       jump_address;
    logic [9:0]       id_pc_plus4;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             id_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks = 0;
    int passed = 0;

    // {valid, pc_plus4, instr} expected in the IF/ID register
    logic [42:0] expQ[$];
    logic [42:0] exp;

    localparam logic [31:0] ADDI_1_5 = 32'h2001_0005;
    localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;
    localparam logic [31:0] ADDI_4_1 = 32'h2004_0001;
    localparam logic [31:0] BEQ_1_2_3 = 32'h1022_0003;
    localparam logic [31:0] BEQ_1_2_2 = 32'h1022_0002;
    localparam logic [31:0] BNE_1_2_3 = 32'h1422_0003;
    localparam logic [31:0] BEQ_4_0_2 = 32'h1080_0002;
    localparam logic [31:0] J_20 = 32'h0800_0020;

    if_id_stage #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_plus4_in    (pc_plus4_in),
        .instr_in       (instr_in),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .ex_mem_read    (ex_mem_read),
        .ex_reg_write   (ex_reg_write),
        .ex_write_reg   (ex_write_reg),
        .mem_mem_read   (mem_mem_read),
        .mem_write_reg  (mem_write_reg),
        .if_en          (if_en),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .jump           (jump),
        .jump_address   (jump_address),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .id_bubble      (id_bubble),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [9:0] pc, input logic [31:0] instr);
        pc_plus4_in = pc;
        instr_in    = instr;
        expQ.push_back({1'b1, pc, instr});
    endtask

    task automatic expect_squash();
        instr_in = 32'hDEAD_BEEF;
        expQ.push_back({1'b0, 10'h000, 32'h0});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({id_valid, id_pc_plus4, id_instr} !== 43'h0)
            $display("[TB] FAIL reset_ifid: got %h want 0", {id_valid, id_pc_plus4, id_instr});
        else passed++;
        checks++;
        if ({if_en, branch_taken, jump, id_bubble, stall_cnt, flush_cnt} !== {4'b1000, 8'h00})
            $display("[TB] FAIL reset_ctrl: got %b want 1000_00000000",
                     {if_en, branch_taken, jump, id_bubble, stall_cnt, flush_cnt});
        else passed++;
        reset = 1'b0;
        fetch(10'h004, ADDI_1_5);
        tick();
        exp = (expQ.size() > 0) ? expQ.pop_front() : 43'h0;
        checks++;
        if ({id_valid, id_pc_plus4, id_instr} !== exp)
            $display("[TB] FAIL first_fetch: got %h want %h", {id_valid, id_pc_plus4, id_instr}, exp);
        else passed++;
        checks++;
        if (if_en !== 1'b1) $display("[TB] FAIL first_if_en: got %b want 1", if_en);
        else passed++;
    endtask

    task automatic test_load_use();
        fetch(10'h008, ADD_3_1_2);
        tick();
        exp = expQ.pop_front();
        ex_mem_read  = 1'b1;
        ex_write_reg = 5'd1;
        pc_plus4_in  = 10'h00C;
        instr_in     = ADDI_4_1;
        #1;
        checks++;
        if ({if_en, id_bubble} !== 2'b01)
            $display("[TB] FAIL loaduse_stall: got if_en/bubble %b want 01", {if_en, id_bubble});
        else passed++;
        tick();
        checks++;
        if ({id_valid, id_pc_plus4, id_instr} !== exp)
            $display("[TB] FAIL loaduse_hold: got %h want %h", {id_valid, id_pc_plus4, id_instr}, exp);
        else passed++;
        checks++;
        if (stall_cnt !== 4'd1) $display("[TB] FAIL loaduse_cnt: got %0d want 1", stall_cnt);
        else passed++;
        ex_mem_read  = 1'b0;
        ex_write_reg = 5'd0;
        #1;
        checks++;
        if ({if_en, id_bubble} !== 2'b10)
            $display("[TB] FAIL loaduse_release: got if_en/bubble %b want 10", {if_en, id_bubble});
        else passed++;
        fetch(10'h00C, ADDI_4_1);
        tick();
        exp = expQ.pop_front();
        checks++;
        if ({id_valid, id_pc_plus4, id_instr} !== exp)
            $display("[TB] FAIL loaduse_next: got %h want %h", {id_valid, id_pc_plus4, id_instr}, exp);
        else passed++;
    endtask

    task automatic test_beq_taken();
        fetch(10'h010, BEQ_1_2_3);
        tick();
        exp = expQ.pop_front();
        rs_data = 32'd7;
        rt_data = 32'd7;
        expect_squash();
        #1;
        checks++;
        if ({branch_taken, jump, branch_address} !== {2'b10, 10'h01C})
            $display("[TB] FAIL beq_taken: got taken/jump/addr %b/%b/%h want 1/0/01c",
                     branch_taken, jump, branch_address);
        else passed++;
        tick();
        exp = expQ.pop_front();
        checks++;
        if ({id_valid, id_pc_plus4, id_instr} !== exp)
            $display("[TB] FAIL beq_flush: got %h want %h", {id_valid, id_pc_plus4, id_instr}, exp);
        else passed++;
        checks++;
        if (flush_cnt !== 4'd1) $display("[TB] FAIL beq_flush_cnt: got %0d want 1", flush_cnt);
        else passed++;
    endtask

    task automatic test_bne_and_wrap();
        fetch(10'h020, BNE_1_2_3);
        tick();
        void'(expQ.pop_front());
        rs_data = 32'd7;
        rt_data = 32'd7;
        fetch(10'h024, ADDI_1_5);
        #1;
        checks++;
        if (branch_taken !== 1'b0) $display("[TB] FAIL bne_equal: got %b want 0", branch_taken);
        else passed++;
        tick();
        exp = expQ.pop_front();
        checks++;
        if ({id_valid, id_pc_plus4, id_instr, flush_cnt} !== {exp, 4'd1})
            $display("[TB] FAIL bne_no_flush: got %h want %h",
                     {id_valid, id_pc_plus4, id_instr, flush_cnt}, {exp, 4'd1});
        else passed++;
        fetch(10'h3FC, BEQ_1_2_2);
        tick();
        void'(expQ.pop_front());
        rs_data = 32'd1;
        rt_data = 32'd2;
        #1;
        checks++;
        if ({branch_taken, branch_address} !== {1'b0, 10'h004})
            $display("[TB] FAIL beq_wrap: got taken/addr %b/%h want 0/004", branch_taken, branch_address);
        else passed++;
    endtask

    task automatic test_branch_stall();
        fetch(10'h100, BEQ_4_0_2);
        tick();
        exp = expQ.pop_front();
        mem_mem_read  = 1'b1;
        mem_write_reg = 5'd4;
        rs_data = 32'd5;
        rt_data = 32'd0;
        instr_in = ADDI_4_1;
        #1;
        checks++;
        if ({if_en, branch_taken, id_bubble} !== 3'b001)
            $display("[TB] FAIL brstall_ctrl: got if_en/taken/bubble %b want 001",
                     {if_en, branch_taken, id_bubble});
        else passed++;
        tick();
        checks++;
        if ({id_valid, id_pc_plus4, id_instr, stall_cnt} !== {exp, 4'd2})
            $display("[TB] FAIL brstall_hold: got %h want %h",
                     {id_valid, id_pc_plus4, id_instr, stall_cnt}, {exp, 4'd2});
        else passed++;
        mem_mem_read  = 1'b0;
        mem_write_reg = 5'd0;
        rs_data = 32'd0;
        expect_squash();
        #1;
        checks++;
        if ({if_en, branch_taken, branch_address} !== {2'b11, 10'h108})
            $display("[TB] FAIL brstall_resolve: got if_en/taken/addr %b/%b/%h want 1/1/108",
                     if_en, branch_taken, branch_address);
        else passed++;
        tick();
        exp = expQ.pop_front();
        checks++;
        if ({id_valid, id_pc_plus4, id_instr, flush_cnt} !== {exp, 4'd2})
            $display("[TB] FAIL brstall_flush: got %h want %h",
                     {id_valid, id_pc_plus4, id_instr, flush_cnt}, {exp, 4'd2});
        else passed++;
    endtask

    task automatic test_jump();
        fetch(10'h200, J_20);
        tick();
        void'(expQ.pop_front());
        expect_squash();
        #1;
        checks++;
        if ({jump, branch_taken, jump_address} !== {2'b10, 10'h080})
            $display("[TB] FAIL jump: got jump/taken/addr %b/%b/%h want 1/0/080",
                     jump, branch_taken, jump_address);
        else passed++;
        tick();
        exp = expQ.pop_front();
        checks++;
        if ({id_valid, id_pc_plus4, id_instr, flush_cnt} !== {exp, 4'd3})
            $display("[TB] FAIL jump_flush: got %h want %h",
                     {id_valid, id_pc_plus4, id_instr, flush_cnt}, {exp, 4'd3});
        else passed++;
    endtask

    task automatic test_saturation_and_async_reset();
        fetch(10'h300, ADD_3_1_2);
        tick();
        void'(expQ.pop_front());
        ex_mem_read  = 1'b1;
        ex_write_reg = 5'd2;
        for (int i = 0; i < 13; i++) tick();
        checks++;
        if (stall_cnt !== 4'hF) $display("[TB] FAIL sat_reach: got %0d want 15", stall_cnt);
        else passed++;
        tick();
        checks++;
        if ({stall_cnt, if_en} !== {4'hF, 1'b0})
            $display("[TB] FAIL sat_hold: got cnt/if_en %0d/%b want 15/0", stall_cnt, if_en);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({id_valid, id_instr, stall_cnt, flush_cnt, if_en, id_bubble} !== {1'b0, 32'h0, 8'h00, 2'b10})
            $display("[TB] FAIL async_reset: got valid/instr/cnts/if_en/bubble %b/%h/%h/%b%b",
                     id_valid, id_instr, {stall_cnt, flush_cnt}, if_en, id_bubble);
        else passed++;
        reset        = 1'b0;
        ex_mem_read  = 1'b0;
        ex_write_reg = 5'd0;
    endtask

    initial begin
        reset = 1'b1;
        pc_plus4_in = '0;
        instr_in = '0;
        rs_data = '0;
        rt_data = '0;
        ex_mem_read = 1'b0;
        ex_reg_write = 1'b0;
        ex_write_reg = '0;
        mem_mem_read = 1'b0;
        mem_write_reg = '0;
        test_reset();
        test_load_use();
        test_beq_taken();
        test_bne_and_wrap();
        test_branch_stall();
        test_jump();
        test_saturation_and_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register with hazard control and early branch/jump resolution for the 5-stage MIPS32 core. Captures the fetch stage's `pc_plus4` and `instr`, decodes `beq`/`bne`/`j` in ID, and drives the fetch stage's `en`, `branch_taken`, `branch_address`, `jump` and `jump_address` inputs. Also detects load-use and branch-operand hazards, inserts bubbles toward ID/EX, and keeps saturating stall/flush counters for performance visibility.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall and flush performance counters.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `pc_plus4_in`  in  10  PC+4 from fetch.
- `instr_in`  in  32  instruction from fetch.
- `rs_data`  in  32  register-file read of `id_instr[25:21]`.
- `rt_data`  in  32  register-file read of `id_instr[20:16]`.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_reg_write`  in  1  instruction in EX writes a register.
- `ex_write_reg`  in  5  destination register of EX.
- `mem_mem_read`  in  1  instruction in MEM is a load.
- `mem_write_reg`  in  5  destination register of MEM.
- `if_en`  out  1  fetch PC enable.
- `branch_taken`  out  1  taken `beq`/`bne` in ID.
- `branch_address`  out  10  branch target.
- `jump`  out  1  `j` in ID.
- `jump_address`  out  10  jump target.
- `id_pc_plus4`  out  10  registered PC+4.
- `id_instr`  out  32  registered instruction.
- `id_valid`  out  1  `id_instr` is a live instruction (not a flush NOP).
- `id_bubble`  out  1  ID/EX must load zeroed control this cycle.
- `stall_cnt`  out  `CNT_W`  saturating count of stall cycles.
- `flush_cnt`  out  `CNT_W`  saturating count of flushes.

## Operation
Decode of `id_instr`: op = `[31:26]`, rs = `[25:21]`, rt = `[20:16]`. Opcodes: `beq` = 6'h04, `bne` = 6'h05, `j` = 6'h02. `rt` counts as a source for R-type (op 0), `beq`, `bne` and `sw` (6'h2B).

Load-use hazard:
- Condition: `ex_mem_read`, `ex_write_reg != 0`, and `ex_write_reg` equals rs, or equals rt when rt is a source.

Branch-operand hazard, for `beq`/`bne` only. Either of:
- `ex_reg_write` and `ex_write_reg != 0` matches rs or rt.
- `mem_mem_read` and `mem_write_reg != 0` matches rs or rt.

`stall` = either hazard and `id_valid`.

When `stall` = 1:
- `if_en` = 0.
- IF/ID register holds its value.
- `id_bubble` = 1.
- `branch_taken` and `jump` are forced to 0.

Branch resolution:
- `branch_taken` = `id_valid` & !stall & ((beq & rs_data==rt_data) | (bne & rs_data!=rt_data)).
- `branch_address` = `id_pc_plus4 + {id_instr[7:0],2'b00}`, modulo 2^10 (wraps).

Jump resolution:
- `jump` = `id_valid` & !stall & (op == j).
- `jump_address` = `{id_instr[7:0],2'b00}`.

`flush` = `branch_taken | jump`. On the next edge, IF/ID loads `instr` = 0, `pc_plus4` = 0, `valid` = 0. There are no delay slots.

Update priority at each edge:
1. stall: hold.
2. flush: load NOP.
3. otherwise: load `pc_plus4_in`/`instr_in` with `valid` = 1.

Counters:
- `stall_cnt` increments on each stall cycle.
- `flush_cnt` increments on each flush cycle.
- Both saturate at all-ones and never wrap.

## Timing
- IF/ID latency: 1 cycle.
- `if_en`, `branch_taken`, `jump`, the targets and `id_bubble` are combinational from the registered state plus the hazard inputs. Fetch sees a redirect in the same cycle and updates its PC at the next edge.
- Reset values:
  - `id_instr` = 0, `id_pc_plus4` = 0, `id_valid` = 0, counters = 0.
  - Hence `if_en` = 1, `branch_taken` = 0, `jump` = 0, `id_bubble` = 0.
- Reset mid-stall or mid-flush: all state clears immediately; the pending redirect is dropped.
- A branch stalled on an operand resolves on the first non-stall cycle using the then-current `rs_data`/`rt_data`.
- A stall lasts as long as its condition holds. Load-use is 1 cycle. A branch after an ALU op is 1 cycle; a branch after a load is 2 cycles.

## Structure
- Shared `mips_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_SW`, `OP_LW`);
  - `NOP_INSTR` = 32'h0;
  - the PC width (10).
- One combinational sub-module `hazard_detect` computes `stall` from the decoded fields and EX/MEM inputs.
- The top level holds the IF/ID registers, branch/jump resolution and counters.

## Test plan
- Reset held 3 cycles, then released with `instr_in` = 32'h2001_0005 at pc_plus4 = 4 -> next cycle `id_instr` = 32'h2001_0005, `id_valid` = 1, `if_en` = 1.
- `id_instr` = lw-dependent `add $3,$1,$2`, with `ex_mem_read` = 1 and `ex_write_reg` = 1 -> exactly 1 cycle of `if_en` = 0 and `id_bubble` = 1, IF/ID held, `stall_cnt` = 1.
- `beq $1,$2` with imm = 3, `id_pc_plus4` = 10'h010, `rs_data` = `rt_data` = 7 -> `branch_taken` = 1, `branch_address` = 10'h01C; next `id_valid` = 0 and `flush_cnt` = 1.
- `bne` with equal operands -> `branch_taken` = 0, no flush. `beq` at `id_pc_plus4` = 10'h3FC with imm = 2 -> `branch_address` = 10'h004 (wrap).
- `beq $4,$0` with `mem_mem_read` = 1 and `mem_write_reg` = 4 -> stall; `branch_taken` = 0 during the stall, then resolves on the following cycle.
- `j` with `instr[7:0]` = 8'h20 -> `jump` = 1, `jump_address` = 10'h080, flush. Drive `stall_cnt` to all-ones, then one further stall -> `stall_cnt` stays all-ones.
